// File: rtl/bldc_pkg.sv
// bldc_pkg: shared constants for the multi-channel BLDC controller.
//   Register word offsets, ID value, CTRL/STATUS bit positions,
//   the hall->gate commutation table and a byte-lane merge helper.
package bldc_pkg;
  localparam logic [2:0] W_ID     = 3'd0;
  localparam logic [2:0] W_PERIOD = 3'd1;
  localparam logic [2:0] W_DUTY   = 3'd2;
  localparam logic [2:0] W_CTRL   = 3'd3;
  localparam logic [2:0] W_STATUS = 3'd4;
  localparam logic [2:0] W_SPEED  = 3'd5;
  localparam logic [2:0] W_DEAD   = 3'd6;

  localparam logic [31:0] BLDC_ID = 32'hEA680104;

  localparam int CTRL_BRAKE = 0;
  localparam int CTRL_DIR   = 1;
  localparam int CTRL_EN    = 2;
  localparam int CTRL_IRQEN = 3;
  localparam int ST_FAULT   = 0;
  localparam int ST_HALLERR = 5;

  // {Ha,Hb,Hc} -> {au,bu,cu,ad,bd,cd}; invalid states give all-off
  function automatic logic [5:0] commutate(input logic [2:0] hall, input logic dir);
    logic [5:0] p;
    p = 6'b000000;
    case (hall)
      3'b100:  p = dir ? 6'b100001 : 6'b001100;
      3'b110:  p = dir ? 6'b010001 : 6'b001010;
      3'b010:  p = dir ? 6'b010100 : 6'b100010;
      3'b011:  p = dir ? 6'b001100 : 6'b100001;
      3'b001:  p = dir ? 6'b001010 : 6'b010001;
      3'b101:  p = dir ? 6'b100010 : 6'b010100;
      default: p = 6'b000000;
    endcase
    return p;
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/bldc_channel.sv
// bldc_channel: one motor channel.
//   Input sync (I_limit, halls), PWM counter with wrap-loaded shadows,
//   commutation/priority select, dead-time gap, latched fault, sticky hall_err,
//   optional hall-period measurement (BLDC_SPEED_MEAS_EN).
// Ports: i_clk/i_rst (async high); i_period/i_duty/i_dead/i_en/i_dir/i_brake config;
//   i_fault_clr/i_herr_clr write-1-clear strobes; i_ilim,i_ha/hb/hc async inputs;
//   o_fault,o_hall_err,o_hall,o_speed,o_spd_valid status; o_gate {au,bu,cu,ad,bd,cd}.
module bldc_channel
  import bldc_pkg::*;
#(
  parameter int PWM_W  = 16,
  parameter int DEAD_W = 8,
  parameter int SPD_W  = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [PWM_W-1:0]  i_period,
  input  logic [PWM_W-1:0]  i_duty,
  input  logic [DEAD_W-1:0] i_dead,
  input  logic              i_en,
  input  logic              i_dir,
  input  logic              i_brake,
  input  logic              i_fault_clr,
  input  logic              i_herr_clr,
  input  logic              i_ilim,
  input  logic              i_ha,
  input  logic              i_hb,
  input  logic              i_hc,
  output logic              o_fault,
  output logic              o_hall_err,
  output logic [2:0]        o_hall,
  output logic [SPD_W-1:0]  o_speed,
  output logic              o_spd_valid,
  output logic [5:0]        o_gate
);
  logic [1:0]        r_ilim_s;
  logic [2:0]        r_hall_s1, r_hall_s2;
  logic [PWM_W-1:0]  r_cnt, r_period_sh, r_duty_sh;
  logic [DEAD_W-1:0] r_dt;
  logic [5:0]        r_tgt, r_gate;
  logic              r_fault, r_hall_err;
  logic              w_wrap, w_pwm_on, w_hall_bad, w_fault_now, w_chg, w_gap;
  logic [5:0]        w_tgt, w_pat;

  assign w_wrap      = (r_cnt >= r_period_sh);
  assign w_pwm_on    = i_en & (r_period_sh != '0) & (r_cnt < r_duty_sh);
  assign w_hall_bad  = (r_hall_s2 == 3'b000) | (r_hall_s2 == 3'b111);
  // a freshly synced over-current blanks outputs in the same edge the fault latches
  assign w_fault_now = r_fault | r_ilim_s[1];

  // target is the un-PWM'd pattern so PWM edges do not trigger dead time
  always_comb begin
    w_tgt = 6'b000000;
    if (w_fault_now || w_hall_bad || !i_en) w_tgt = 6'b000000;
    else if (i_brake)                       w_tgt = 6'b000111;
    else                                    w_tgt = commutate(r_hall_s2, i_dir);
  end

  assign w_chg = (w_tgt != r_tgt);
  // r_dt holds remaining gap cycles including the current one; the last gap cycle is r_dt==2
  assign w_gap = w_chg ? (i_dead != '0) : (r_dt > DEAD_W'(1));
  assign w_pat = w_chg ? w_tgt : r_tgt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ilim_s    <= '0;
      r_hall_s1   <= '0;
      r_hall_s2   <= '0;
      r_cnt       <= '0;
      r_period_sh <= '0;
      r_duty_sh   <= '0;
      r_dt        <= '0;
      r_tgt       <= '0;
      r_gate      <= '0;
      r_fault     <= 1'b0;
      r_hall_err  <= 1'b0;
    end else begin
      r_ilim_s  <= {r_ilim_s[0], i_ilim};
      r_hall_s1 <= {i_ha, i_hb, i_hc};
      r_hall_s2 <= r_hall_s1;

      if (w_wrap) begin
        r_cnt       <= '0;
        r_period_sh <= i_period;
        r_duty_sh   <= i_duty;
      end else begin
        r_cnt <= r_cnt + PWM_W'(1);
      end

      if (w_chg) begin
        r_tgt <= w_tgt;
        r_dt  <= i_dead;
      end else if (r_dt != '0) begin
        r_dt <= r_dt - DEAD_W'(1);
      end

      // low side stays on through the PWM off-time
      if (w_fault_now || w_gap) r_gate <= 6'b000000;
      else                      r_gate <= w_pat & {{3{w_pwm_on}}, 3'b111};

      if (r_ilim_s[1])      r_fault <= 1'b1;
      else if (i_fault_clr) r_fault <= 1'b0;

      // halls are only meaningful while driving; idle sensors must not raise errors
      if (i_en && w_hall_bad) r_hall_err <= 1'b1;
      else if (i_herr_clr)    r_hall_err <= 1'b0;
    end
  end

`ifdef BLDC_SPEED_MEAS_EN
  logic [2:0]       r_hall_prev;
  logic [SPD_W-1:0] r_spd_cnt, r_speed;
  logic             r_spd_valid, w_hchg, w_sat;

  assign w_hchg = (r_hall_s2 != r_hall_prev);
  assign w_sat  = &r_spd_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hall_prev <= '0;
      r_spd_cnt   <= '0;
      r_speed     <= '0;
      r_spd_valid <= 1'b0;
    end else begin
      r_hall_prev <= r_hall_s2;
      if (w_hchg) begin
        r_spd_cnt   <= '0;
        r_speed     <= w_sat ? r_spd_cnt : r_spd_cnt + SPD_W'(1);
        r_spd_valid <= ~w_sat;
      end else if (w_sat) begin
        r_speed     <= r_spd_cnt;
        r_spd_valid <= 1'b0;
      end else begin
        r_spd_cnt <= r_spd_cnt + SPD_W'(1);
      end
    end
  end

  assign o_speed     = r_speed;
  assign o_spd_valid = r_spd_valid;
`else
  assign o_speed     = '0;
  assign o_spd_valid = 1'b0;
`endif

  assign o_fault    = r_fault;
  assign o_hall_err = r_hall_err;
  assign o_hall     = r_hall_s2;
  assign o_gate     = r_gate;
endmodule

// File: rtl/bldc_multi_ctrl.sv
// bldc_multi_ctrl: NUM_CH sensored BLDC commutation channels behind an Avalon-MM slave.
//   Holds per-channel PERIOD/DUTY/CTRL/DEADTIME, bus decode, registered read mux, IRQ OR.
//   Optional macro BLDC_SPEED_MEAS_EN enables hall-period measurement (SPEED, spd_valid).
// Ports: csi_MCLK_clk, rsi_MRST_reset (async high); avs_ctrl_* Avalon slave
//   (address = {channel, word[2:0]}); ins_irq; I_limit, Ha/Hb/Hc per channel;
//   Lau/Lbu/Lcu/Lad/Lbd/Lcd gate drives per channel.
module bldc_multi_ctrl
  import bldc_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int PWM_W  = 16,
  parameter int DEAD_W = 8,
  parameter int SPD_W  = 24
) (
  input  logic                         csi_MCLK_clk,
  input  logic                         rsi_MRST_reset,
  input  logic [3+$clog2(NUM_CH)-1:0]  avs_ctrl_address,
  input  logic [31:0]                  avs_ctrl_writedata,
  input  logic [3:0]                   avs_ctrl_byteenable,
  input  logic                         avs_ctrl_write,
  input  logic                         avs_ctrl_read,
  output logic [31:0]                  avs_ctrl_readdata,
  output logic                         avs_ctrl_waitrequest,
  output logic                         ins_irq,
  input  logic [NUM_CH-1:0]            I_limit,
  input  logic [NUM_CH-1:0]            Ha,
  input  logic [NUM_CH-1:0]            Hb,
  input  logic [NUM_CH-1:0]            Hc,
  output logic [NUM_CH-1:0]            Lau,
  output logic [NUM_CH-1:0]            Lbu,
  output logic [NUM_CH-1:0]            Lcu,
  output logic [NUM_CH-1:0]            Lad,
  output logic [NUM_CH-1:0]            Lbd,
  output logic [NUM_CH-1:0]            Lcd
);
  localparam int AW = 3 + $clog2(NUM_CH);

  logic [NUM_CH-1:0][PWM_W-1:0]  r_period, r_duty;
  logic [NUM_CH-1:0][DEAD_W-1:0] r_dead;
  logic [NUM_CH-1:0][3:0]        r_ctrl;
  logic [31:0]                   r_rdata, w_rd;
  logic [AW-1:0]                 w_ch;
  logic [2:0]                    w_word;
  logic [NUM_CH-1:0]             w_wr_ch, w_fclr, w_hclr, w_fault, w_herr, w_spd_valid, w_irq_ch;
  logic [NUM_CH-1:0][2:0]        w_hall;
  logic [NUM_CH-1:0][SPD_W-1:0]  w_speed;
  logic [NUM_CH-1:0][5:0]        w_gate;

  assign w_ch   = AW'(avs_ctrl_address >> 3);
  assign w_word = avs_ctrl_address[2:0];

  // decoded per-channel write strobe; channels >= NUM_CH never match
  always_comb begin
    w_wr_ch = '0;
    for (int c = 0; c < NUM_CH; c++)
      w_wr_ch[c] = avs_ctrl_write & (w_ch == AW'(c));
  end

  assign w_fclr = w_wr_ch & {NUM_CH{(w_word == W_STATUS) & avs_ctrl_writedata[ST_FAULT]}};
  assign w_hclr = w_wr_ch & {NUM_CH{(w_word == W_STATUS) & avs_ctrl_writedata[ST_HALLERR]}};

  always_comb begin
    w_rd = 32'h0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch == AW'(c)) begin
        case (w_word)
          W_ID:     w_rd = BLDC_ID;
          W_PERIOD: w_rd = 32'(r_period[c]);
          W_DUTY:   w_rd = 32'(r_duty[c]);
          W_CTRL:   w_rd = {28'h0, r_ctrl[c]};
          W_STATUS: w_rd = {26'h0, w_herr[c], w_spd_valid[c], w_hall[c], w_fault[c]};
          W_SPEED:  w_rd = 32'(w_speed[c]);
          W_DEAD:   w_rd = 32'(r_dead[c]);
          default:  w_rd = 32'h0;
        endcase
      end
    end
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_period <= '0;
      r_duty   <= '0;
      r_dead   <= '0;
      r_ctrl   <= '0;
      r_rdata  <= '0;
    end else begin
      r_rdata <= avs_ctrl_read ? w_rd : 32'h0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr_ch[c]) begin
          case (w_word)
            W_PERIOD: r_period[c] <= PWM_W'(be_merge(32'(r_period[c]), avs_ctrl_writedata, avs_ctrl_byteenable));
            W_DUTY:   r_duty[c]   <= PWM_W'(be_merge(32'(r_duty[c]), avs_ctrl_writedata, avs_ctrl_byteenable));
            W_CTRL:   r_ctrl[c]   <= avs_ctrl_writedata[3:0];
            W_DEAD:   r_dead[c]   <= DEAD_W'(be_merge(32'(r_dead[c]), avs_ctrl_writedata, avs_ctrl_byteenable));
            default: ;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    bldc_channel #(.PWM_W(PWM_W), .DEAD_W(DEAD_W), .SPD_W(SPD_W)) u_ch (
      .i_clk       (csi_MCLK_clk),
      .i_rst       (rsi_MRST_reset),
      .i_period    (r_period[g]),
      .i_duty      (r_duty[g]),
      .i_dead      (r_dead[g]),
      .i_en        (r_ctrl[g][CTRL_EN]),
      .i_dir       (r_ctrl[g][CTRL_DIR]),
      .i_brake     (r_ctrl[g][CTRL_BRAKE]),
      .i_fault_clr (w_fclr[g]),
      .i_herr_clr  (w_hclr[g]),
      .i_ilim      (I_limit[g]),
      .i_ha        (Ha[g]),
      .i_hb        (Hb[g]),
      .i_hc        (Hc[g]),
      .o_fault     (w_fault[g]),
      .o_hall_err  (w_herr[g]),
      .o_hall      (w_hall[g]),
      .o_speed     (w_speed[g]),
      .o_spd_valid (w_spd_valid[g]),
      .o_gate      (w_gate[g])
    );
    assign {Lau[g], Lbu[g], Lcu[g], Lad[g], Lbd[g], Lcd[g]} = w_gate[g];
    assign w_irq_ch[g] = (w_fault[g] | w_herr[g]) & r_ctrl[g][CTRL_IRQEN];
  end

  assign ins_irq              = |w_irq_ch;
  assign avs_ctrl_readdata    = r_rdata;
  assign avs_ctrl_waitrequest = 1'b0;
endmodule

// File: tb/tb_bldc_multi_ctrl.sv
module tb_bldc_multi_ctrl;
  localparam int NUM_CH = 2;
  localparam int AW     = 4;

  logic              clk = 1'b0, rst = 1'b1;
  logic [AW-1:0]     addr = '0;
  logic [31:0]       wdata = '0, rdata;
  logic [3:0]        be = 4'hF;
  logic              wr = 1'b0, rd = 1'b0, waitreq, irq;
  logic [NUM_CH-1:0] ilim = '0, ha = '0, hb = '0, hc = '0;
  logic [NUM_CH-1:0] lau, lbu, lcu, lad, lbd, lcd;

  int n_chk = 0, n_pass = 0;

  bldc_multi_ctrl #(.NUM_CH(NUM_CH), .PWM_W(16), .DEAD_W(8), .SPD_W(24)) dut (
    .csi_MCLK_clk(clk), .rsi_MRST_reset(rst),
    .avs_ctrl_address(addr), .avs_ctrl_writedata(wdata), .avs_ctrl_byteenable(be),
    .avs_ctrl_write(wr), .avs_ctrl_read(rd), .avs_ctrl_readdata(rdata),
    .avs_ctrl_waitrequest(waitreq), .ins_irq(irq),
    .I_limit(ilim), .Ha(ha), .Hb(hb), .Hc(hc),
    .Lau(lau), .Lbu(lbu), .Lcu(lcu), .Lad(lad), .Lbd(lbd), .Lcd(lcd));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [5:0] pat(input int c);
    return {lau[c], lbu[c], lcu[c], lad[c], lbd[c], lcd[c]};
  endfunction

  task automatic bus_write(input int ch, input int word, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    addr = AW'(ch * 8 + word); wdata = d; be = b; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0; be = 4'hF;
  endtask

  task automatic bus_read(input int ch, input int word, output logic [31:0] d);
    @(negedge clk);
    addr = AW'(ch * 8 + word); rd = 1'b1;
    @(negedge clk);
    rd = 1'b0; d = rdata;
  endtask

  task automatic set_hall0(input logic [2:0] h);
    @(negedge clk);
    {ha[0], hb[0], hc[0]} = h;
  endtask

  typedef struct {
    int          ch;
    int          word;
    bit          wr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [31:0] d;
    int n1, n2, nz, nlow, nlcd;
    bit found, prev;

    tbl[0]  = '{0, 0, 1'b0, 4'hF, 32'h0,        32'hEA680104};
    tbl[1]  = '{1, 0, 1'b0, 4'hF, 32'h0,        32'hEA680104};
    tbl[2]  = '{0, 1, 1'b0, 4'hF, 32'h0,        32'h0};
    tbl[3]  = '{0, 4, 1'b0, 4'hF, 32'h0,        32'h0};
    tbl[4]  = '{0, 1, 1'b1, 4'hF, 32'h12345678, 32'h5678};
    tbl[5]  = '{0, 1, 1'b1, 4'h1, 32'hAAAA0000, 32'h5600};
    tbl[6]  = '{0, 2, 1'b1, 4'h2, 32'h0000BBCC, 32'hBB00};
    tbl[7]  = '{0, 0, 1'b1, 4'hF, 32'hFFFFFFFF, 32'hEA680104};
    tbl[8]  = '{0, 5, 1'b1, 4'hF, 32'h0000FFFF, 32'h0};
    tbl[9]  = '{0, 7, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0};
    tbl[10] = '{1, 6, 1'b1, 4'hF, 32'h000001FF, 32'hFF};
    tbl[11] = '{1, 3, 1'b1, 4'hF, 32'h0000000A, 32'hA};
    tbl[12] = '{0, 3, 1'b0, 4'hF, 32'h0,        32'h0};
    tbl[13] = '{1, 3, 1'b1, 4'hF, 32'h0,        32'h0};

    // reset state
    repeat (3) @(negedge clk);
    check("reset_gates", {26'h0, pat(0)}, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("waitrequest", {31'h0, waitreq}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) bus_write(tbl[i].ch, tbl[i].word, tbl[i].wd, tbl[i].be);
      bus_read(tbl[i].ch, tbl[i].word, d);
      check($sformatf("reg_vec%0d", i), d, tbl[i].exp);
    end

    // fresh start so the PWM shadows are not stuck in a long period
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    // PWM 25/100, hall 100, dir=1
    bus_write(0, 1, 32'd99, 4'hF);
    bus_write(0, 2, 32'd25, 4'hF);
    set_hall0(3'b100);
    bus_write(0, 3, 32'h6, 4'hF);
    repeat (300) @(negedge clk);
    n1 = 0; nlcd = 0; nlow = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n1 += int'(lau[0]); nlcd += int'(lcd[0]);
      nlow += int'(lbu[0] | lcu[0] | lad[0] | lbd[0]);
    end
    check("pwm25_lau_on", n1, 25);
    check("pwm25_lcd_on", nlcd, 100);
    check("pwm25_others", nlow, 0);

    // duty change mid-period takes effect at the next wrap
    found = 1'b0; prev = 1'b1;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (lau[0] && !prev) found = 1'b1;
      prev = lau[0];
    end
    check("pwm_start_found", {31'h0, found}, 32'h1);
    n1 = 1; n2 = 0;
    fork
      begin
        for (int i = 0; i < 99; i++) begin @(negedge clk); n1 += int'(lau[0]); end
        for (int i = 0; i < 100; i++) begin @(negedge clk); n2 += int'(lau[0]); end
      end
      begin
        repeat (40) @(negedge clk);
        bus_write(0, 2, 32'd75, 4'hF);
      end
    join
    check("duty_cur_period", n1, 25);
    check("duty_next_period", n2, 75);

    // dead time 10 on hall 100 -> 110, with 100% duty
    bus_write(0, 2, 32'd200, 4'hF);
    bus_write(0, 6, 32'd10, 4'hF);
    repeat (250) @(negedge clk);
    check("dt_before", {26'h0, pat(0)}, 32'b100001);
    set_hall0(3'b110);
    nz = 0; found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (pat(0) == 6'b000000) nz++;
      else if (pat(0) == 6'b010001) found = 1'b1;
    end
    check("dt_zero_cycles", nz, 10);
    check("dt_new_pattern", {31'h0, found}, 32'h1);

    // over-current: one-cycle pulse, latched fault, IRQ, guarded clear
    bus_write(0, 3, 32'hE, 4'hF);
    @(negedge clk); ilim[0] = 1'b1;
    @(negedge clk); ilim[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("fault_gates_off", {26'h0, pat(0)}, 32'h0);
    bus_read(0, 4, d);
    check("fault_status", d, 32'hD);
    check("fault_irq", {31'h0, irq}, 32'h1);
    @(negedge clk); ilim[0] = 1'b1;
    repeat (5) @(negedge clk);
    bus_write(0, 4, 32'h1, 4'hF);
    bus_read(0, 4, d);
    check("fault_clr_ignored", d, 32'hD);
    @(negedge clk); ilim[0] = 1'b0;
    repeat (5) @(negedge clk);
    bus_write(0, 4, 32'h1, 4'hF);
    bus_read(0, 4, d);
    check("fault_cleared", d, 32'hC);
    check("fault_irq_gone", {31'h0, irq}, 32'h0);
    repeat (30) @(negedge clk);
    check("fault_resume", {26'h0, pat(0)}, 32'b010001);

    // invalid hall -> off, sticky hall_err
    set_hall0(3'b111);
    repeat (5) @(negedge clk);
    check("hall111_off", {26'h0, pat(0)}, 32'h0);
    set_hall0(3'b011);
    repeat (30) @(negedge clk);
    bus_read(0, 4, d);
    check("hallerr_sticky", d, 32'h26);
    check("hallerr_irq", {31'h0, irq}, 32'h1);
    check("hall011_dir1", {26'h0, pat(0)}, 32'b001100);
    bus_write(0, 4, 32'h20, 4'hF);
    bus_read(0, 4, d);
    check("hallerr_clr", d, 32'h6);

    // dir=0 then brake, each through dead time
    bus_write(0, 3, 32'h4, 4'hF);
    repeat (30) @(negedge clk);
    check("hall011_dir0", {26'h0, pat(0)}, 32'b100001);
    bus_write(0, 3, 32'h5, 4'hF);
    repeat (30) @(negedge clk);
    check("brake", {26'h0, pat(0)}, 32'b000111);
    check("ch1_idle", {26'h0, pat(1)}, 32'h0);

`ifdef BLDC_SPEED_MEAS_EN
    @(negedge clk); {ha[1], hb[1], hc[1]} = 3'b100;
    repeat (1000) @(negedge clk); {ha[1], hb[1], hc[1]} = 3'b110;
    repeat (1000) @(negedge clk); {ha[1], hb[1], hc[1]} = 3'b010;
    repeat (10) @(negedge clk);
    bus_read(1, 5, d);
    check("speed_1000", {31'h0, (d >= 32'd999 && d <= 32'd1001)}, 32'h1);
    bus_read(1, 4, d);
    check("spd_valid", {31'h0, d[4]}, 32'h1);
`else
    bus_read(0, 5, d);
    check("speed_disabled", d, 32'h0);
`endif

    // asynchronous reset mid-operation
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("async_rst_gates", {26'h0, pat(0)}, 32'h0);
    @(negedge clk); rst = 1'b0;
    bus_read(0, 3, d);
    check("rst_ctrl_cleared", d, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
